// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: one shared 50 Hz frame counter,
// per-channel target/current angles with per-frame slew limit and output enable.
module servo_pwm_multi #(
    parameter int unsigned CLK_HZ     = 25_000_000,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned INIT_ANGLE = 170,
    parameter int unsigned SLEW_STEP  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [3:0]      wr_ch,
    input  logic [7:0]      wr_angle,
    input  logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] servo_out,
    output logic [N_CH-1:0] busy,
    output logic            frame_tick
);
    localparam int unsigned PERIOD_TICKS = CLK_HZ / 50;
    localparam int unsigned MIN_TICKS    = CLK_HZ / 1000;
    localparam int unsigned MAX_TICKS    = 2 * MIN_TICKS;
    localparam int unsigned SPAN_TICKS   = MAX_TICKS - MIN_TICKS;
    localparam int unsigned CNT_W        = $clog2(PERIOD_TICKS);
    localparam logic [7:0]  MAX_ANGLE    = 8'd180;
    localparam logic [7:0]  STEP         = 8'(SLEW_STEP);
    localparam logic [7:0]  INIT         = 8'(INIT_ANGLE);

    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tgt     [N_CH];
    logic [7:0]       r_cur     [N_CH];
    logic [7:0]       w_tgt_nxt [N_CH];
    logic [7:0]       w_cur_nxt [N_CH];
    logic [7:0]       w_diff    [N_CH];
    logic [31:0]      w_pulse   [N_CH];
    logic [7:0]       w_wr_sat;
    logic             w_boundary;

    assign w_boundary = (r_cnt == CNT_W'(PERIOD_TICKS - 1));
    assign w_wr_sat   = (wr_angle > MAX_ANGLE) ? MAX_ANGLE : wr_angle;

    // Next target/current per channel; slew uses the target held before this cycle's write
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_tgt_nxt[i] = r_tgt[i];
            w_cur_nxt[i] = r_cur[i];
            w_diff[i]    = (r_tgt[i] > r_cur[i]) ? (r_tgt[i] - r_cur[i]) : (r_cur[i] - r_tgt[i]);
            w_pulse[i]   = 32'(MIN_TICKS) + (32'(SPAN_TICKS) * 32'(r_cur[i])) / 32'd180;
            if (wr_en && (wr_ch == 4'(i))) begin
                w_tgt_nxt[i] = w_wr_sat;
            end
            if (w_boundary) begin
                if ((STEP == 8'd0) || (w_diff[i] <= STEP)) begin
                    w_cur_nxt[i] = r_tgt[i];
                end else if (r_tgt[i] > r_cur[i]) begin
                    w_cur_nxt[i] = r_cur[i] + STEP;
                end else begin
                    w_cur_nxt[i] = r_cur[i] - STEP;
                end
            end
        end
    end

    // Frame counter, angle state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            frame_tick <= 1'b0;
            servo_out  <= '0;
            busy       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_tgt[i] <= INIT;
                r_cur[i] <= INIT;
            end
        end else begin
            r_cnt      <= w_boundary ? '0 : (r_cnt + CNT_W'(1));
            frame_tick <= w_boundary;
            for (int i = 0; i < N_CH; i++) begin
                r_tgt[i]     <= w_tgt_nxt[i];
                r_cur[i]     <= w_cur_nxt[i];
                servo_out[i] <= ch_en[i] & (32'(r_cnt) < w_pulse[i]);
                busy[i]      <= (w_cur_nxt[i] != w_tgt_nxt[i]);
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: dut0 slews 2 deg/frame, dut1 jumps in one frame
// (SLEW_STEP=0); both at CLK_HZ=50_000 so a frame is 1000 cycles.
module tb_servo_pwm_multi;
    localparam int EN_F = 20;
    localparam int EN_J = 30;
    localparam int BW_F = 10;

    typedef struct {
        int ch;
        int angle;
        int exp_w;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en0, wr_en1;
    logic [3:0] wr_ch;
    logic [7:0] wr_angle;
    logic [3:0] ch_en;
    logic [3:0] servo0, busy0, servo1, busy1;
    logic       ft0, ft1;

    servo_pwm_multi #(.CLK_HZ(50_000), .N_CH(4), .INIT_ANGLE(170), .SLEW_STEP(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_ch(wr_ch), .wr_angle(wr_angle),
        .ch_en(ch_en), .servo_out(servo0), .busy(busy0), .frame_tick(ft0));

    servo_pwm_multi #(.CLK_HZ(50_000), .N_CH(4), .INIT_ANGLE(170), .SLEW_STEP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_ch(wr_ch), .wr_angle(wr_angle),
        .ch_en(ch_en), .servo_out(servo1), .busy(busy1), .frame_tick(ft1));

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   w0[4], w1[4];
    int   m_cur[4], m_tgt[4];
    int   pend_ch, pend_val;
    int   n_tick, t_pos, busy_frames;
    logic [3:0] busy_pre, busy_post0, busy_post1, busy_w0, busy_w1;
    logic [1:0] en_smp;
    vec_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    function automatic int sat(input int a);
        return (a > 180) ? 180 : a;
    endfunction

    function automatic int exp_w(input int a);
        return 50 + (50 * a) / 180;
    endfunction

    task automatic drv0(input int ch, input int a, input bit bnd);
        wr_en0 = 1'b1; wr_ch = 4'(ch); wr_angle = 8'(a);
        if (ch < 4) begin
            if (bnd) begin pend_ch = ch; pend_val = sat(a); end
            else m_tgt[ch] = sat(a);
        end
    endtask

    task automatic drv1(input int ch, input int a);
        wr_en1 = 1'b1; wr_ch = 4'(ch); wr_angle = 8'(a);
    endtask

    // Entered on the frame_tick cycle (cnt==0); sample j sees cnt==j+1 (mod 1000)
    task automatic run_frame(input int f);
        for (int c = 0; c < 4; c++) begin w0[c] = 0; w1[c] = 0; end
        n_tick = 0; t_pos = -1;
        for (int j = 0; j < 1000; j++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (servo0[c]) w0[c]++;
                if (servo1[c]) w1[c]++;
            end
            if (ft0) begin n_tick++; t_pos = j; end
            if (j == 1)   busy_w0 = busy0;
            if (j == 6)   busy_w1 = busy1;
            if (j == 998) busy_pre = busy0;
            if (j == 999) begin busy_post0 = busy0; busy_post1 = busy1; end
            if (f == EN_F && j == EN_J)     en_smp[0] = servo0[3];
            if (f == EN_F && j == EN_J + 1) en_smp[1] = servo0[3];
            wr_en0 = 1'b0; wr_en1 = 1'b0;
            if (f == 0) begin
                case (j)
                    0: drv0(0, 10, 1'b0);
                    1: drv0(7, 0, 1'b0);
                    2: drv0(2, 5, 1'b0);
                    3: drv0(2, 250, 1'b0);
                    default: ;
                endcase
            end
            if (f >= 0 && f < 10 && j == 5) drv1(tbl[f].ch, tbl[f].angle);
            if (f == BW_F && j == 998) drv0(3, 160, 1'b1);
            if (f == EN_F && j == EN_J) ch_en = 4'h7;
            if (f == EN_F && j == 500) ch_en = 4'hF;
        end
    endtask

    task automatic do_frame(input int f);
        int ew[4];
        for (int c = 0; c < 4; c++) ew[c] = exp_w(m_cur[c]);
        if (f == EN_F) ew[3] = EN_J + 1;
        pend_ch = -1;
        run_frame(f);
        for (int c = 0; c < 4; c++)
            chk($sformatf("f%0d dut0 width ch%0d", f, c), w0[c], ew[c]);
        for (int c = 0; c < 4; c++) begin
            if (m_tgt[c] - m_cur[c] > 2)       m_cur[c] += 2;
            else if (m_cur[c] - m_tgt[c] > 2)  m_cur[c] -= 2;
            else                               m_cur[c] = m_tgt[c];
        end
        if (pend_ch >= 0) m_tgt[pend_ch] = pend_val;
        for (int c = 0; c < 4; c++)
            chk($sformatf("f%0d dut0 busy ch%0d", f, c), int'(busy_post0[c]), int'(m_cur[c] != m_tgt[c]));
        chk($sformatf("f%0d frame_tick count", f), n_tick, 1);
        chk($sformatf("f%0d frame_tick pos", f), t_pos, 999);
        if (f >= 0 && busy_pre[0]) busy_frames++;
        if (f == 0)    chk("write-to-busy latency ch0", int'(busy_w0[0]), 1);
        if (f == EN_F) begin
            chk("ch_en drop before", int'(en_smp[0]), 1);
            chk("ch_en drop after", int'(en_smp[1]), 0);
        end
        if (f == 11) chk("boundary write deferred ch3", w0[3], 97);
        if (f == 12) chk("boundary write first step ch3", w0[3], 96);
        if (f == 80) begin
            chk("slew final width ch0", w0[0], 52);
            chk("saturated final width ch2", w0[2], 100);
        end
        if (f < 0) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("idle dut1 width ch%0d", c), w1[c], 97);
                chk($sformatf("idle dut1 busy ch%0d", c), int'(busy_post1[c]), 0);
            end
        end
        if (f >= 0 && f < 10) begin
            chk($sformatf("v%0d dut1 busy rise", f), int'(busy_w1[tbl[f].ch]), 1);
            chk($sformatf("v%0d dut1 busy after boundary", f), int'(busy_post1[tbl[f].ch]), 0);
        end
        if (f >= 1 && f <= 10)
            chk($sformatf("v%0d dut1 width", f - 1), w1[tbl[f - 1].ch], tbl[f - 1].exp_w);
        if (f == 1) begin
            chk("dut1 untouched ch0", w1[0], 97);
            chk("dut1 untouched ch3", w1[3], 97);
        end
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin @(negedge clk); k++; end while (!ft0 && k < 1100);
        chk("frame_tick found", int'(ft0), 1);
    endtask

    initial begin
        tbl[0] = '{1, 90, 75};
        tbl[1] = '{2, 250, 100};
        tbl[2] = '{0, 0, 50};
        tbl[3] = '{1, 180, 100};
        tbl[4] = '{2, 36, 60};
        tbl[5] = '{0, 255, 100};
        tbl[6] = '{1, 179, 99};
        tbl[7] = '{2, 1, 50};
        tbl[8] = '{0, 4, 51};
        tbl[9] = '{1, 181, 100};
        for (int c = 0; c < 4; c++) begin m_cur[c] = 170; m_tgt[c] = 170; end
        busy_frames = 0;
        rst_n = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0;
        wr_ch = 4'd0; wr_angle = 8'd0; ch_en = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset servo0", int'(servo0), 0);
        chk("reset busy0", int'(busy0), 0);
        chk("reset frame_tick0", int'(ft0), 0);
        chk("reset servo1", int'(servo1), 0);
        chk("reset busy1", int'(busy1), 0);
        rst_n = 1'b1;
        wait_tick();

        for (int f = -1; f < 82; f++) do_frame(f);
        chk("ch0 busy boundaries", busy_frames, 80);

        // Reset asserted mid-pulse while ch1 is slewing
        wr_en0 = 1'b1; wr_ch = 4'd1; wr_angle = 8'd0;
        @(negedge clk);
        wr_en0 = 1'b0;
        repeat (39) @(negedge clk);
        chk("pre-reset servo0 ch1", int'(servo0[1]), 1);
        chk("pre-reset busy0 ch1", int'(busy0[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("async reset servo0", int'(servo0), 0);
        chk("async reset busy0", int'(busy0), 0);
        chk("async reset servo1", int'(servo1), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin m_cur[c] = 170; m_tgt[c] = 170; end
        wait_tick();
        do_frame(-1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
